// File: rtl/cpu_pkg.sv
// Shared CPU definitions: muldiv opcodes, muldiv FSM states, widths and a
// two's-complement helper used for operand magnitudes and result sign fixup.
package cpu_pkg;
  localparam int MD_WIDTH = 32;
  localparam int MD_ITERS = MD_WIDTH;
  localparam int MD_DW    = 2 * MD_WIDTH;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} md_state_e;

  // Conditional negate; callers zero-extend narrower values and truncate back.
  function automatic logic [MD_DW-1:0] twos_neg(input logic [MD_DW-1:0] v, input logic neg);
    return neg ? (~v + MD_DW'(1)) : v;
  endfunction
endpackage

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. One shared
// 2*WIDTH shift register does shift-add multiply and restoring divide.
module ex_muldiv_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);
  localparam int DW    = 2 * WIDTH;
  localparam int CW    = $clog2(WIDTH);
  localparam int ITERS = WIDTH;

  md_state_e        state;
  logic [CW-1:0]    cnt;
  logic             div_q, res_neg, rem_neg, dbz_pend, dbz_q;
  logic [WIDTH-1:0] raw_rs, opb, hi_q, lo_q;
  logic [DW-1:0]    acc;

  md_op_e           op;
  logic             accept, is_div, is_signed, rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  assign op        = md_op_e'(op_i);
  assign accept    = (state == IDLE) && start_i && !flush_i;
  assign is_div    = (op == MD_DIV) || (op == MD_DIVU);
  assign is_signed = (op == MD_MULT) || (op == MD_DIV);
  assign rs_neg    = is_signed & rs_data_i[WIDTH-1];
  assign rt_neg    = is_signed & rt_data_i[WIDTH-1];
  assign rs_mag    = WIDTH'(twos_neg(MD_DW'(rs_data_i), rs_neg));
  assign rt_mag    = WIDTH'(twos_neg(MD_DW'(rt_data_i), rt_neg));

  // Multiply: acc = {partial product, remaining multiplier bits}, shifting right.
  logic [WIDTH:0] mul_sum;
  logic [DW-1:0]  mul_next;
  assign mul_sum  = {1'b0, acc[DW-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}, shifting left one bit per step.
  logic [WIDTH:0] div_trial;
  logic [DW-1:0]  div_next;
  assign div_trial = acc[DW-1:WIDTH-1] - {1'b0, opb};
  assign div_next  = div_trial[WIDTH] ? {acc[DW-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  logic [DW-1:0]    prod;
  logic [WIDTH-1:0] quo, rem;
  assign prod = DW'(twos_neg(MD_DW'(acc), res_neg));
  assign quo  = WIDTH'(twos_neg(MD_DW'(acc[WIDTH-1:0]), res_neg));
  assign rem  = WIDTH'(twos_neg(MD_DW'(acc[DW-1:WIDTH]), rem_neg));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      div_q    <= 1'b0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      dbz_pend <= 1'b0;
      dbz_q    <= 1'b0;
      raw_rs   <= '0;
      opb      <= '0;
      acc      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state    <= CALC;
          cnt      <= '0;
          div_q    <= is_div;
          res_neg  <= rs_neg ^ rt_neg;
          rem_neg  <= rs_neg;
          dbz_pend <= is_div && (rt_data_i == '0);
          dbz_q    <= 1'b0;
          raw_rs   <= rs_data_i;
          opb      <= is_div ? rt_mag : rs_mag;
          acc      <= {{WIDTH{1'b0}}, is_div ? rs_mag : rt_mag};
        end
        CALC: if (flush_i) begin
          state <= IDLE;
        end else begin
          acc <= div_q ? div_next : mul_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(ITERS - 1)) state <= FIX;
        end
        FIX: if (flush_i) begin
          state <= IDLE;
        end else begin
          state <= DONE;
          dbz_q <= dbz_pend;
          if (!div_q) begin
            hi_q <= prod[DW-1:WIDTH];
            lo_q <= prod[WIDTH-1:0];
          end else if (dbz_pend) begin
            hi_q <= raw_rs;
            lo_q <= '1;
          end else begin
            hi_q <= rem;
            lo_q <= quo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o        = accept || (state == CALC) || (state == FIX);
  assign done_o        = (state == DONE);
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_by_zero_o = dbz_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: arithmetic/timing reference model checked every
// cycle, plus directed vectors with literal expected results.
module tb_ex_muldiv_unit;
  logic        clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, flush_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] rs_data_i = '0, rt_data_i = '0;
  logic        busy_o, done_o, div_by_zero_o;
  logic [31:0] hi_o, lo_o;
  logic        clk_en = 1'b1;

  int checks = 0, errors = 0;
  int bcnt = 0, dcnt = 0;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .flush_i(flush_i),
    .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o),
    .div_by_zero_o(div_by_zero_o)
  );

  initial forever begin
    #5;
    if (clk_en) clk_i = ~clk_i;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference results from plain integer arithmetic.
  function automatic void calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] h, output logic [31:0] l, output logic z);
    logic [63:0] p, q, r;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z  = 1'b0;
    case (op)
      2'b00: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
      2'b10: if (b == 0) begin h = a; l = '1; z = 1'b1; end
             else begin q = 64'(sa / sb); r = 64'(sa % sb); h = r[31:0]; l = q[31:0]; end
      default: if (b == 0) begin h = a; l = '1; z = 1'b1; end
               else begin h = a % b; l = a / b; end
    endcase
  endfunction

  // Model timing: age = cycles since acceptance (1..32 iterate, 33 fixup,
  // 34 completion), -1 when idle.
  int          age = -1;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_dbz = 1'b0, p_z = 1'b0;

  always @(posedge clk_i or posedge rst_i) begin
    logic [31:0] th, tl;
    logic        tz;
    if (rst_i) begin
      age <= -1; m_hi <= '0; m_lo <= '0; m_dbz <= 1'b0;
    end else if (age < 0) begin
      if (start_i && !flush_i) begin
        calc(op_i, rs_data_i, rt_data_i, th, tl, tz);
        p_hi <= th; p_lo <= tl; p_z <= tz; m_dbz <= 1'b0; age <= 1;
      end
    end else if (age <= 33 && flush_i) age <= -1;
    else if (age == 33) begin
      m_hi <= p_hi; m_lo <= p_lo; m_dbz <= p_z; age <= 34;
    end else if (age == 34) age <= -1;
    else age <= age + 1;
  end

  always @(negedge clk_i) begin
    if (!rst_i) begin
      chk("busy", 32'(busy_o), 32'((age < 0 && start_i && !flush_i) || (age >= 1 && age <= 33)));
      chk("done", 32'(done_o), 32'(age == 34));
      chk("hi", hi_o, m_hi);
      chk("lo", lo_o, m_lo);
      chk("dbz", 32'(div_by_zero_o), 32'(m_dbz));
      if (busy_o) bcnt++;
      if (done_o) dcnt++;
    end
  end

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    op_i = op; rs_data_i = a; rt_data_i = b; start_i = 1'b1;
    bcnt = 0; dcnt = 0;
  endtask

  // From cycle 0 run through completion and land in the following idle cycle.
  task automatic finish();
    int n = 0;
    @(posedge clk_i); #1 start_i = 1'b0;
    while (!done_o && n < 40) begin @(posedge clk_i); #1; n++; end
    if (!done_o) begin
      errors++;
      $display("FAIL timeout waiting for done_o got=0 exp=1");
    end
    @(posedge clk_i); #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    launch(op, a, b);
    finish();
  endtask

  initial begin
    #12;
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_lo", lo_o, 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_hi", hi_o, 32'hFFFFFFFE);
    chk("multu_lo", lo_o, 32'h00000001);
    chk("multu_busy_cycles", 32'(bcnt), 32'd34);
    chk("multu_done_pulses", 32'(dcnt), 32'd1);

    run_op(2'b00, -32'sd3, 32'd7);
    chk("mult_hi", hi_o, 32'hFFFFFFFF);
    chk("mult_lo", lo_o, 32'hFFFFFFEB);

    run_op(2'b10, -32'sd7, 32'd2);
    chk("div_lo", lo_o, 32'hFFFFFFFD);
    chk("div_hi", hi_o, 32'hFFFFFFFF);

    run_op(2'b11, 32'd100, 32'd7);
    chk("divu_lo", lo_o, 32'h0000000E);
    chk("divu_hi", hi_o, 32'h00000002);

    run_op(2'b11, 32'd5, 32'd0);
    chk("dbz_lo", lo_o, 32'hFFFFFFFF);
    chk("dbz_hi", hi_o, 32'h00000005);
    chk("dbz_flag", 32'(div_by_zero_o), 32'd1);
    launch(2'b01, 32'd2, 32'd3);
    @(posedge clk_i); #1;
    chk("dbz_cleared", 32'(div_by_zero_o), 32'd0);
    finish();
    chk("multu_small_lo", lo_o, 32'd6);

    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
    chk("ovf_lo", lo_o, 32'h80000000);
    chk("ovf_hi", hi_o, 32'h0);
    chk("ovf_flag", 32'(div_by_zero_o), 32'd0);

    // Flush in CALC cycle 10: prior HI/LO must survive.
    launch(2'b11, 32'd1000, 32'd3);
    @(posedge clk_i); #1 start_i = 1'b0;
    repeat (9) begin @(posedge clk_i); #1; end
    flush_i = 1'b1;
    @(posedge clk_i); #1 flush_i = 1'b0;
    chk("flush_busy", 32'(busy_o), 32'd0);
    chk("flush_lo", lo_o, 32'h80000000);
    chk("flush_hi", hi_o, 32'h0);
    repeat (30) begin @(posedge clk_i); #1; end
    chk("flush_no_done", 32'(dcnt), 32'd0);

    // Held start: exactly one completion, then a new MULT accepted in cycle 35.
    launch(2'b01, 32'd3, 32'd4);
    repeat (35) begin @(posedge clk_i); #1; end
    chk("held_done_pulses", 32'(dcnt), 32'd1);
    chk("held_lo", lo_o, 32'd12);
    op_i = 2'b00; rs_data_i = 32'h80000000; rt_data_i = 32'd2;
    #1 chk("held_busy_c35", 32'(busy_o), 32'd1);
    bcnt = 0; dcnt = 0;
    finish();
    chk("mult_min_hi", hi_o, 32'hFFFFFFFF);
    chk("mult_min_lo", lo_o, 32'h00000000);

    // Reset in cycle 20 with the clock stopped.
    launch(2'b00, 32'd9, 32'd9);
    @(posedge clk_i); #1 start_i = 1'b0;
    repeat (19) begin @(posedge clk_i); #1; end
    clk_en = 1'b0;
    rst_i  = 1'b1;
    #1;
    chk("arst_hi", hi_o, 32'h0);
    chk("arst_lo", lo_o, 32'h0);
    chk("arst_busy", 32'(busy_o), 32'h0);
    chk("arst_done", 32'(done_o), 32'h0);
    chk("arst_dbz", 32'(div_by_zero_o), 32'h0);
    #2 rst_i = 1'b0;
    clk_en = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    run_op(2'b10, 32'd7, -32'sd2);
    chk("div_negdiv_lo", lo_o, 32'hFFFFFFFD);
    chk("div_negdiv_hi", hi_o, 32'h00000001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
